add_operand_loader: RTL and testbench

- Upstream stage of the 128-bit parallel adder top.
- Collects two W-bit operands and a carry-in from a narrow D-bit input stream using a valid/ready handshake.
- Presents the completed operands as stable parallel outputs, then asserts a one-cycle `enable` pulse so the adder's input registers capture them.
- Keeps a running count of issued operations.

---
 rtl/add_operand_loader_if.sv | 27 ++
 rtl/add_operand_loader.sv | 108 ++++++++++
 tb/tb_add_operand_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/add_operand_loader_if.sv
// Operand-loader bus: narrow beat stream in, parallel operands and capture strobe out.
// The loader sits on the slave side of the stream. The feeder/observer sits on the master side.
interface add_operand_loader_if #(
   parameter int W  = 128,
   parameter int D  = 8,
   parameter int CW = 16
);
   logic          in_valid;
   logic [D-1:0]  in_data;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          C_in;
   logic          enable;
   logic [CW-1:0] op_count;
   logic [1:0]    state_o;

   modport slave (
      input  in_valid, in_data,
      output in_ready, A, B, C_in, enable, op_count, state_o
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, A, B, C_in, enable, op_count, state_o
   );
endinterface

// File: rtl/add_operand_loader.sv
// Assembles two W-bit operands and a carry from a D-bit beat stream (LSB beat first).
// It then strobes enable for one cycle so the downstream adder captures them.
module add_operand_loader #(
   parameter int W  = 128,
   parameter int D  = 8,
   parameter int CW = 16
) (
   input  logic                 CLK_50,
   input  logic                 reset,
   add_operand_loader_if.slave  bus
);

   localparam int N     = W / D;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      LOAD_C = 2'd2,
      ISSUE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     a_q, b_q;
   logic             c_q;
   logic             en_q;
   logic [CW-1:0]    cnt_q;
   logic             ready;
   logic             accept;
   logic             last_beat;

   // The new beat enters at the top, so after N beats the first one sits in the LSBs.
   // Widening before the shift keeps this legal when W == D.
   function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur,
                                             input logic [D-1:0] beat);
      logic [W+D-1:0] cat;
      cat = {beat, cur} >> D;
      return cat[W-1:0];
   endfunction

   assign accept    = bus.in_valid && ready;
   assign last_beat = (idx == IDX_LAST);

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         state <= LOAD_A;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b1;
      case (state)
         LOAD_A: if (accept && last_beat) state_nxt = LOAD_B;
         LOAD_B: if (accept && last_beat) state_nxt = LOAD_C;
         LOAD_C: if (accept)              state_nxt = ISSUE;
         ISSUE: begin
            ready     = 1'b0;
            state_nxt = LOAD_A;
         end
         default: state_nxt = LOAD_A;
      endcase
   end

   always_ff @(posedge CLK_50) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= 1'b0;
         idx   <= '0;
         en_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         // enable tracks the registered state: high exactly while the FSM sits in ISSUE
         en_q <= (state_nxt == ISSUE);
         if (state == ISSUE) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (accept) begin
            case (state)
               LOAD_A: begin
                  a_q <= shift_in(a_q, bus.in_data);
                  idx <= last_beat ? '0 : idx + 1'b1;
               end
               LOAD_B: begin
                  b_q <= shift_in(b_q, bus.in_data);
                  idx <= last_beat ? '0 : idx + 1'b1;
               end
               LOAD_C: c_q <= bus.in_data[0];
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready = ready;
   assign bus.A        = a_q;
   assign bus.B        = b_q;
   assign bus.C_in     = c_q;
   assign bus.enable   = en_q;
   assign bus.op_count = cnt_q;
   assign bus.state_o  = state;

endmodule

// File: tb/tb_add_operand_loader.sv
// Randomized bench for add_operand_loader. A beat-queue reference model predicts the outputs.
// A second instance with a 2-bit counter shares the stimulus so op_count wrap is visible.
module tb_add_operand_loader;
   localparam int W = 128;
   localparam int D = 8;
   localparam int N = W / D;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   add_operand_loader_if #(.W(W), .D(D), .CW(16)) bus ();
   add_operand_loader_if #(.W(W), .D(D), .CW(2))  bus2 ();

   assign bus2.in_valid = bus.in_valid;
   assign bus2.in_data  = bus.in_data;

   add_operand_loader #(.W(W), .D(D), .CW(16)) dut (
      .CLK_50(clk), .reset(reset), .bus(bus));
   add_operand_loader #(.W(W), .D(D), .CW(2)) dut_cw2 (
      .CLK_50(clk), .reset(reset), .bus(bus2));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: beats of the current operation in arrival order, plus pending source beats
   logic [D-1:0] q[$];
   logic [D-1:0] src[$];
   bit           issue = 1'b0;
   bit           fresh = 1'b1;
   int unsigned  ops   = 0;
   int           gap_pct = 0;
   logic [W-1:0] last_a, last_b;
   logic         last_c;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [W-1:0] ea, eb;
      logic         ec;
      logic [1:0]   es;
      ea = '0;
      eb = '0;
      ec = 1'b0;
      if (issue)               es = 2'd3;
      else if (q.size() < N)   es = 2'd0;
      else if (q.size() < 2*N) es = 2'd1;
      else                     es = 2'd2;
      chk("in_ready",     W'(bus.in_ready),  W'(!issue));
      chk("enable",       W'(bus.enable),    W'(issue));
      chk("state_o",      W'(bus.state_o),   W'(es));
      chk("op_count",     W'(bus.op_count),  W'(ops % 65536));
      chk("cw2_in_ready", W'(bus2.in_ready), W'(!issue));
      chk("cw2_enable",   W'(bus2.enable),   W'(issue));
      chk("cw2_state_o",  W'(bus2.state_o),  W'(es));
      chk("cw2_op_count", W'(bus2.op_count), W'(ops % 4));
      if (issue) begin
         for (int i = 0; i < N; i++) begin
            ea += W'(q[i])     << (D * i);
            eb += W'(q[N + i]) << (D * i);
         end
         ec = q[2*N][0];
         last_a = bus.A;
         last_b = bus.B;
         last_c = bus.C_in;
      end
      if (issue || fresh) begin
         chk("A",        bus.A,         ea);
         chk("B",        bus.B,         eb);
         chk("C_in",     W'(bus.C_in),  W'(ec));
         chk("cw2_A",    bus2.A,        ea);
         chk("cw2_B",    bus2.B,        eb);
         chk("cw2_C_in", W'(bus2.C_in), W'(ec));
      end
   endtask

   task automatic cycle(input bit rst_i);
      bit take;
      @(negedge clk);
      check_outputs();
      reset = rst_i;
      take = (src.size() > 0) && (int'($urandom_range(99)) >= gap_pct);
      bus.in_valid = take || rst_i;
      bus.in_data  = take ? src[0] : D'($urandom);
      @(posedge clk);
      if (rst_i) begin
         q.delete();
         issue = 1'b0;
         fresh = 1'b1;
         ops   = 0;
      end else if (issue) begin
         issue = 1'b0;
         ops++;
         q.delete();
      end else if (bus.in_valid) begin
         q.push_back(bus.in_data);
         if (take) void'(src.pop_front());
         fresh = 1'b0;
         if (q.size() == 2*N + 1) issue = 1'b1;
      end
   endtask

   task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [D-1:0] cbeat);
      for (int i = 0; i < N; i++) src.push_back(a[D*i +: D]);
      for (int i = 0; i < N; i++) src.push_back(b[D*i +: D]);
      src.push_back(cbeat);
   endtask

   task automatic drain();
      int budget = 5000;
      while ((src.size() > 0 || issue) && budget > 0) begin
         cycle(1'b0);
         budget--;
      end
      cycle(1'b0);
   endtask

   function automatic logic [W-1:0] rand_op();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [W-1:0] pat_a;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // Reset with in_valid asserted
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b0);

      // Back-to-back known operation
      gap_pct = 0;
      for (int i = 0; i < N; i++) pat_a[D*i +: D] = D'(i + 1);
      push_op(pat_a, '1, 8'h01);
      drain();
      chk("t2_A",  last_a, 128'h100F0E0D0C0B0A090807060504030201);
      chk("t2_B",  last_b, {W{1'b1}});
      chk("t2_C",  W'(last_c), W'(1'b1));
      chk("t2_cnt", W'(bus.op_count), W'(1));

      // Random gaps
      gap_pct = 50;
      push_op({4{32'hDEADBEEF}}, 128'h1, 8'h00);
      drain();
      chk("t3_A", last_a, {4{32'hDEADBEEF}});
      chk("t3_B", last_b, 128'h1);
      chk("t3_C", W'(last_c), W'(1'b0));

      // Reset after 10 A beats, then a full new operation
      gap_pct = 0;
      push_op(rand_op(), rand_op(), 8'h01);
      for (int i = 0; i < 10; i++) cycle(1'b0);
      src.delete();
      cycle(1'b1);
      push_op(rand_op(), rand_op(), D'($urandom));
      drain();
      chk("t4_cnt", W'(bus.op_count), W'(1));

      // in_valid held high across two operations
      push_op(rand_op(), rand_op(), D'($urandom));
      push_op(rand_op(), rand_op(), D'($urandom));
      drain();

      // Counter wrap on the 2-bit instance
      cycle(1'b1);
      for (int k = 0; k < 5; k++) begin
         gap_pct = (k % 2) * 30;
         push_op(rand_op(), rand_op(), D'($urandom));
         drain();
      end
      chk("t6_cw2_cnt", W'(bus2.op_count), W'(1));

      // Reset during ISSUE truncates the pulse and clears the count
      gap_pct = 20;
      push_op(rand_op(), rand_op(), D'($urandom));
      for (int i = 0; i < 5000 && !issue; i++) cycle(1'b0);
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b0);

      // Random operations with random gaps, carry beats with random upper bits
      for (int k = 0; k < 6; k++) begin
         gap_pct = int'($urandom_range(60));
         push_op(rand_op(), rand_op(), D'($urandom));
         drain();
      end
      for (int i = 0; i < 4; i++) cycle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
